// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: frame-rate tick generator that streams sync, packet bytes MSB-first
// and an XOR checksum to a ready/valid UART transmitter.
module frame_tx_scheduler #(
    parameter int PACKET_BYTES = 22,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int FRAME_DIV = 1666667
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [8*PACKET_BYTES-1:0] packet,
    input  logic                      tx_ready,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    output logic                      busy,
    output logic                      frame_sent,
    output logic [7:0]                overrun_cnt
);
    localparam int W = 8*PACKET_BYTES;
    localparam int DW = $clog2(FRAME_DIV);
    localparam int IW = $clog2(PACKET_BYTES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(PACKET_BYTES - 1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} state_t;
    state_t state, state_nx;
    logic [DW-1:0] div;
    logic [W-1:0] snap, snap_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [7:0] csum, csum_nx;
    logic tick, sent_nx;

    assign tick = div == DIV_LAST;
    assign busy = state != IDLE;
    assign tx_valid = busy;

    // The snapshot shifts left on each payload transfer, so the next byte is always on top.
    always_comb begin
        state_nx = state;
        snap_nx = snap;
        idx_nx = idx;
        csum_nx = csum;
        sent_nx = 1'b0;
        tx_data = 8'h00;
        case (state)
            IDLE: if (tick && enable) begin
                state_nx = SYNC;
                snap_nx = packet;
                idx_nx = '0;
                csum_nx = '0;
            end
            SYNC: begin
                tx_data = SYNC_BYTE;
                if (tx_ready) state_nx = DATA;
            end
            DATA: begin
                tx_data = snap[W-1 -: 8];
                if (tx_ready) begin
                    snap_nx = snap << 8;
                    csum_nx = csum ^ snap[W-1 -: 8];
                    idx_nx = idx + 1'b1;
                    if (idx == IDX_LAST) state_nx = CSUM;
                end
            end
            CSUM: begin
                tx_data = csum;
                if (tx_ready) begin
                    state_nx = IDLE;
                    sent_nx = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            div <= '0;
            snap <= '0;
            idx <= '0;
            csum <= '0;
            frame_sent <= 1'b0;
            overrun_cnt <= 8'h00;
        end else begin
            state <= state_nx;
            div <= tick ? '0 : div + 1'b1;
            snap <= snap_nx;
            idx <= idx_nx;
            csum <= csum_nx;
            frame_sent <= sent_nx;
            if (tick && busy && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_frame_tx_scheduler.sv
// tb_frame_tx_scheduler: directed scenarios plus random traffic checked every cycle
// against a byte-queue model of the frame scheduler.
module tb_frame_tx_scheduler;
    localparam int PB = 22;
    localparam int FD = 10;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, tx_ready = 1'b0;
    logic [8*PB-1:0] packet = '0, pkt1;
    logic [7:0] tx_data, overrun_cnt;
    logic tx_valid, busy, frame_sent;

    int tests = 0, fails = 0, frames = 0, cyc_n = 0, rise_cyc = 0, sent_cyc = 0;
    logic [7:0] got[$];
    logic [7:0] m_q[$];
    int m_div = 0, m_ovr = 0;
    logic m_sent = 1'b0, armed = 1'b0, prev_valid = 1'b0;
    logic m_tick, m_busy;
    logic [7:0] m_x, m_d;

    always #5 clk = ~clk;

    frame_tx_scheduler #(.PACKET_BYTES(PB), .SYNC_BYTE(8'hA5), .FRAME_DIV(FD)) dut (
        .clk(clk), .rst(rst), .enable(enable), .packet(packet), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .frame_sent(frame_sent),
        .overrun_cnt(overrun_cnt)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sent(string nm);
        int n0 = frames;
        for (int k = 0; k < 400 && frames == n0; k++) cyc();
        chk(nm, 32'(frames > n0), 1);
    endtask

    task automatic wait_got(int n, string nm);
        for (int k = 0; k < 400 && got.size() < n; k++) cyc();
        chk(nm, 32'(got.size() >= n), 1);
    endtask

    // Model: the frame is a queue of bytes still to send; the head is what must be offered.
    always @(negedge clk) begin
        cyc_n++;
        if (armed) begin
            m_busy = m_q.size() > 0;
            m_d = m_busy ? m_q[0] : 8'h00;
            tests++;
            if (tx_valid !== m_busy || busy !== m_busy || frame_sent !== m_sent ||
                overrun_cnt !== m_ovr[7:0] || (m_busy && tx_data !== m_d)) begin
                fails++;
                $display("FAIL cycle %0d: valid %b busy %b sent %b ovr %0d data %h, expected valid %b sent %b ovr %0d data %h",
                         cyc_n, tx_valid, busy, frame_sent, overrun_cnt, tx_data, m_busy, m_sent, m_ovr, m_d);
            end
            if (tx_valid && tx_ready) got.push_back(tx_data);
            if (frame_sent) begin
                frames++;
                sent_cyc = cyc_n;
            end
            if (tx_valid && !prev_valid) rise_cyc = cyc_n;
            prev_valid = tx_valid;
        end
        if (rst) begin
            m_q.delete();
            m_div = 0;
            m_ovr = 0;
            m_sent = 1'b0;
            armed = 1'b1;
        end else begin
            m_tick = m_div == FD - 1;
            m_div = m_tick ? 0 : m_div + 1;
            m_busy = m_q.size() > 0;
            m_sent = m_q.size() == 1 && tx_ready;
            if (m_busy && tx_ready) void'(m_q.pop_front());
            if (m_tick && m_busy) m_ovr = m_ovr == 255 ? 255 : m_ovr + 1;
            else if (m_tick && enable) begin
                m_q.push_back(8'hA5);
                m_x = 8'h00;
                for (int i = 0; i < PB; i++) begin
                    m_q.push_back(packet[8*PB-1-8*i -: 8]);
                    m_x ^= packet[8*PB-1-8*i -: 8];
                end
                m_q.push_back(m_x);
            end
        end
    end

    initial begin
        int k, o0;
        for (int i = 0; i < PB; i++) pkt1[8*(PB-i)-1 -: 8] = 8'(i + 1);
        repeat (3) cyc();
        chk("reset_valid", 32'(tx_valid), 0);
        chk("reset_data", 32'(tx_data), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ovr", 32'(overrun_cnt), 0);

        // Scenario 1: full-rate frame with bytes 01..16
        packet = pkt1;
        enable = 1'b1;
        tx_ready = 1'b1;
        got.delete();
        rst = 1'b0;
        wait_sent("s1_timeout");
        chk("s1_count", 32'(got.size()), 24);
        chk("s1_sync", 32'(got[0]), 32'hA5);
        chk("s1_first", 32'(got[1]), 32'h01);
        chk("s1_last", 32'(got[22]), 32'h16);
        chk("s1_csum", 32'(got[23]), 32'h17);
        chk("s1_latency", 32'(sent_cyc - rise_cyc), 24);

        // Scenario 2: tx_ready toggling every cycle
        got.delete();
        k = frames;
        for (int n = 0; n < 300 && frames == k; n++) begin
            tx_ready = ~tx_ready;
            cyc();
        end
        chk("s2_done", 32'(frames > k), 1);
        chk("s2_count", 32'(got.size()), 24);
        chk("s2_csum", 32'(got[23]), 32'h17);

        // Scenario 3: 30-cycle stall mid-DATA with packet churning underneath
        tx_ready = 1'b1;
        got.delete();
        wait_got(5, "s3_wait");
        o0 = int'(overrun_cnt);
        tx_ready = 1'b0;
        repeat (30) begin
            packet = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            cyc();
        end
        chk("s3_overruns", 32'(int'(overrun_cnt) - o0), 3);
        packet = pkt1;
        tx_ready = 1'b1;
        wait_sent("s3_timeout");
        chk("s3_count", 32'(got.size()), 24);
        chk("s3_csum", 32'(got[23]), 32'h17);

        // Scenario 4: packet changes one cycle after the tick
        got.delete();
        for (k = 0; k < 20 && !busy; k++) cyc();
        chk("s4_start", 32'(busy), 1);
        packet = '1;
        wait_sent("s4_old_timeout");
        chk("s4_old_first", 32'(got[1]), 32'h01);
        chk("s4_old_csum", 32'(got[23]), 32'h17);
        got.delete();
        wait_sent("s4_new_timeout");
        chk("s4_new_count", 32'(got.size()), 24);
        chk("s4_new_first", 32'(got[1]), 32'hFF);
        chk("s4_new_csum", 32'(got[23]), 32'h00);

        // Scenario 5: reset in the middle of the payload
        got.delete();
        wait_got(6, "s5_wait");
        rst = 1'b1;
        cyc();
        chk("s5_valid", 32'(tx_valid), 0);
        chk("s5_busy", 32'(busy), 0);
        chk("s5_ovr", 32'(overrun_cnt), 0);
        rst = 1'b0;
        got.delete();
        for (k = 0; k < 30 && !tx_valid; k++) cyc();
        chk("s5_restart_cycles", 32'(k), 10);
        chk("s5_restart_sync", 32'(tx_data), 32'hA5);
        wait_sent("s5_timeout");
        chk("s5_count", 32'(got.size()), 24);

        // Scenario 6: enable low across two ticks
        enable = 1'b0;
        got.delete();
        o0 = int'(overrun_cnt);
        repeat (22) cyc();
        chk("s6_idle_bytes", 32'(got.size()), 0);
        chk("s6_idle_ovr", 32'(int'(overrun_cnt) - o0), 0);
        enable = 1'b1;
        for (k = 0; k < 12 && !busy; k++) cyc();
        chk("s6_start", 32'(busy), 1);

        // Long stall saturates the overrun counter
        tx_ready = 1'b0;
        repeat (2700) cyc();
        chk("sat_ovr", 32'(overrun_cnt), 255);
        tx_ready = 1'b1;
        wait_sent("sat_timeout");

        // Random traffic, checked cycle by cycle by the model
        for (int n = 0; n < 3000; n++) begin
            enable = $urandom_range(0, 9) != 0;
            tx_ready = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 299) == 0;
            if ($urandom_range(0, 7) == 0)
                packet = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            cyc();
        end
        rst = 1'b0;
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
